// File: rtl/updn_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: load Lo, count to Hi, back to Lo, N times.
// Optional SWEEP_ABORT_EN macro adds an Abort input and a sticky Aborted status output.
module updn_sweep_ctrl #(
  parameter int WIDTH   = 5,
  parameter int SWEEP_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Lo_Bound,
  input  logic [WIDTH-1:0]   Hi_Bound,
  input  logic [SWEEP_W-1:0] Sweeps,
  input  logic [WIDTH-1:0]   Cnt_Val,
  input  logic               Cnt_High,
  input  logic               Cnt_Low,
`ifdef SWEEP_ABORT_EN
  input  logic               Abort,
  output logic               Aborted,
`endif
  output logic [WIDTH-1:0]   Cnt_IN,
  output logic               Cnt_Load,
  output logic               Cnt_Up,
  output logic               Cnt_Down,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [SWEEP_W-1:0] Sweep_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [SWEEP_W-1:0] n_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic [SWEEP_W-1:0] sweep_d;
  logic               err_q;
  logic               abort_act;
  logic               up_ok;
  logic               dn_ok;

  assign sweep_d = sweep_q + 1'b1;
  assign Busy    = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DOWN);
  assign Done    = (state_q == S_DONE);

`ifdef SWEEP_ABORT_EN
  logic aborted_q;
  assign abort_act = Abort && Busy;
  assign Aborted   = aborted_q;
`else
  assign abort_act = 1'b0;
`endif

  // The High/Low guards keep the counter from wrapping even if a bound sits at an extreme.
  assign up_ok = (Cnt_Val < hi_q) && !Cnt_High;
  assign dn_ok = (Cnt_Val > lo_q) && !Cnt_Low;

  always_comb begin
    Cnt_Load = 1'b0;
    Cnt_Up   = 1'b0;
    Cnt_Down = 1'b0;
    Cnt_IN   = '0;
    if (!abort_act) begin
      case (state_q)
        S_LOAD: begin
          Cnt_Load = 1'b1;
          Cnt_IN   = lo_q;
        end
        S_UP:    Cnt_Up   = up_ok;
        S_DOWN:  Cnt_Down = dn_ok;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= '0;
      sweep_q   <= '0;
      err_q     <= 1'b0;
`ifdef SWEEP_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else if (abort_act) begin
      // Abort wins over any sweep bookkeeping in the same cycle.
      state_q   <= S_DONE;
`ifdef SWEEP_ABORT_EN
      aborted_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            lo_q      <= Lo_Bound;
            hi_q      <= Hi_Bound;
            n_q       <= Sweeps;
            sweep_q   <= '0;
            err_q     <= 1'b0;
`ifdef SWEEP_ABORT_EN
            aborted_q <= 1'b0;
`endif
            if (Lo_Bound > Hi_Bound) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (Sweeps == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: state_q <= S_UP;
        S_UP: begin
          if (Cnt_Val >= hi_q) state_q <= S_DOWN;
        end
        S_DOWN: begin
          if (Cnt_Val <= lo_q) begin
            sweep_q <= sweep_d;
            state_q <= (sweep_d == n_q) ? S_DONE : S_UP;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Err       = err_q;
  assign Sweep_Cnt = sweep_q;

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Scoreboard bench for updn_sweep_ctrl with a behavioural 5-bit up/down counter attached.
// Expected per-run totals come from closed-form sweep arithmetic; a monitor checks them on Done.
module tb_updn_sweep_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Start = 1'b0;
  logic [4:0] Lo_Bound = '0;
  logic [4:0] Hi_Bound = '0;
  logic [3:0] Sweeps = '0;
  logic [4:0] Cnt_Val;
  logic       Cnt_High, Cnt_Low;
  logic [4:0] Cnt_IN;
  logic       Cnt_Load, Cnt_Up, Cnt_Down, Busy, Done, Err;
  logic [3:0] Sweep_Cnt;
`ifdef SWEEP_ABORT_EN
  logic       Abort = 1'b0;
  logic       Aborted;
`endif

  updn_sweep_ctrl #(.WIDTH(5), .SWEEP_W(4)) dut (
    .CLK(CLK), .RST(RST), .Start(Start),
    .Lo_Bound(Lo_Bound), .Hi_Bound(Hi_Bound), .Sweeps(Sweeps),
    .Cnt_Val(Cnt_Val), .Cnt_High(Cnt_High), .Cnt_Low(Cnt_Low),
`ifdef SWEEP_ABORT_EN
    .Abort(Abort), .Aborted(Aborted),
`endif
    .Cnt_IN(Cnt_IN), .Cnt_Load(Cnt_Load), .Cnt_Up(Cnt_Up), .Cnt_Down(Cnt_Down),
    .Busy(Busy), .Done(Done), .Err(Err), .Sweep_Cnt(Sweep_Cnt)
  );

  always #5 CLK = ~CLK;

  // External counter: not touched by the controller's reset.
  logic [4:0] cnt_q = '0;
  always @(posedge CLK) begin
    if (Cnt_Load)      cnt_q <= Cnt_IN;
    else if (Cnt_Up)   cnt_q <= cnt_q + 5'd1;
    else if (Cnt_Down) cnt_q <= cnt_q - 5'd1;
  end
  assign Cnt_Val  = cnt_q;
  assign Cnt_High = (cnt_q == 5'd31);
  assign Cnt_Low  = (cnt_q == 5'd0);

  typedef struct {
    int busy; int ups; int downs; int loads;
    int err; int sweeps; int fin; int chk_fin; int aborted;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int m_busy = 0, m_up = 0, m_dn = 0, m_ld = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int lo, input int hi, input int n);
    exp_t e;
    e = '{default: 0};
    if (lo > hi) begin
      e.err = 1;
    end else if (n > 0) begin
      e.busy    = 1 + 2 * n * (hi - lo + 1);
      e.ups     = n * (hi - lo);
      e.downs   = n * (hi - lo);
      e.loads   = 1;
      e.sweeps  = n;
      e.fin     = lo;
      e.chk_fin = 1;
    end
    return e;
  endfunction

  // Monitor: per-cycle command sanity, per-run totals compared when Done is presented.
  always @(negedge CLK) begin
    if (RST) begin
      m_busy = 0; m_up = 0; m_dn = 0; m_ld = 0;
    end else begin
      chk("cmd_sanity",
          int'(($countones({Cnt_Load, Cnt_Up, Cnt_Down}) <= 1) &&
               (Cnt_Load || Cnt_IN == 5'd0) &&
               !(Cnt_Up && Cnt_Val == 5'd31) && !(Cnt_Down && Cnt_Val == 5'd0)), 1);
      if (Busy)     m_busy++;
      if (Cnt_Up)   m_up++;
      if (Cnt_Down) m_dn++;
      if (Cnt_Load) m_ld++;
      if (Done) begin
        exp_t e;
        chk("done_busy_low", int'(Busy), 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("busy_cycles", m_busy, e.busy);
          chk("up_pulses", m_up, e.ups);
          chk("down_pulses", m_dn, e.downs);
          chk("load_pulses", m_ld, e.loads);
          chk("err", int'(Err), e.err);
          chk("sweep_cnt", int'(Sweep_Cnt), e.sweeps);
          if (e.chk_fin != 0) chk("final_cnt_val", int'(Cnt_Val), e.fin);
`ifdef SWEEP_ABORT_EN
          chk("aborted", int'(Aborted), e.aborted);
`endif
        end
        done_count++;
        m_busy = 0; m_up = 0; m_dn = 0; m_ld = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int c = 0; c < 2000; c++) begin
      @(posedge CLK); #1;
      if (!Busy && !Done) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_done(input int start_done);
    for (int c = 0; c < 2000 && done_count == start_done; c++) begin
      Lo_Bound = 5'($urandom);
      Hi_Bound = 5'($urandom);
      Sweeps   = 4'($urandom);
      @(posedge CLK); #1;
    end
    if (done_count == start_done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int lo, input int hi, input int n, input bit spurious);
    exp_t e;
    int   sd;
    wait_idle();
    Lo_Bound = 5'(lo); Hi_Bound = 5'(hi); Sweeps = 4'(n);
    Start = 1'b1;
    e = model(lo, hi, n);
    q.push_back(e);
    sd = done_count;
    @(posedge CLK); #1;
    Start = 1'b0;
    if (spurious) begin
      @(posedge CLK); #1;
      Start = 1'b1;
      Lo_Bound = 5'(hi); Hi_Bound = 5'(31); Sweeps = 4'd15;
      @(posedge CLK); #1;
      Start = 1'b0;
    end
    wait_done(sd);
    chk("sweep_cnt_hold", int'(Sweep_Cnt), e.sweeps);
    chk("err_hold", int'(Err), e.err);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", int'({Busy, Done, Err, Cnt_Load, Cnt_Up, Cnt_Down, Cnt_IN, Sweep_Cnt}), 0);
    RST = 1'b0;

    run(3, 6, 1, 1'b0);
    run(0, 31, 2, 1'b0);
    run(9, 5, 3, 1'b0);
    run(7, 7, 2, 1'b0);
    run(7, 7, 0, 1'b0);
    run(2, 20, 2, 1'b1);

    // Asynchronous reset while counting up through 4.
    wait_idle();
    Lo_Bound = 5'd1; Hi_Bound = 5'd10; Sweeps = 4'd2; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int c = 0; c < 50 && !(Busy && Cnt_Val == 5'd4); c++) begin
      @(posedge CLK); #1;
    end
    chk("pre_reset_up", int'(Cnt_Up), 1);
    #2 RST = 1'b1;
    q.delete();
    #1;
    chk("async_reset_outputs",
        int'({Busy, Done, Err, Cnt_Load, Cnt_Up, Cnt_Down, Cnt_IN, Sweep_Cnt}), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    run(4, 8, 1, 1'b0);

`ifdef SWEEP_ABORT_EN
    begin
      exp_t e;
      int   sd;
      int   lo = 5, hi = 9, L;
      L = hi - lo + 1;
      wait_idle();
      Lo_Bound = 5'(lo); Hi_Bound = 5'(hi); Sweeps = 4'd3; Start = 1'b1;
      e = '{default: 0};
      e.busy = 3 * L + 2; e.ups = 2 * (L - 1); e.downs = L - 1; e.loads = 1;
      e.sweeps = 1; e.fin = hi; e.chk_fin = 1; e.aborted = 1;
      q.push_back(e);
      sd = done_count;
      @(posedge CLK); #1;
      Start = 1'b0;
      repeat (3 * L + 1) @(posedge CLK);
      #1 Abort = 1'b1;
      @(posedge CLK); #1;
      Abort = 1'b0;
      chk("abort_done_next", int'(Done), 1);
      wait_done(sd);
      chk("aborted_sticky", int'(Aborted), 1);
      run(1, 3, 1, 1'b0);
      chk("aborted_cleared", int'(Aborted), 0);
    end
`endif

    for (int i = 0; i < 20; i++) begin
      int lo, hi, n, t;
      bit sp;
      lo = $urandom_range(0, 31);
      hi = $urandom_range(0, 31);
      if ($urandom_range(0, 3) != 0 && lo > hi) begin
        t = lo; lo = hi; hi = t;
      end
      n  = $urandom_range(0, 15);
      sp = (lo <= hi) && (n > 0) && ($urandom_range(0, 1) == 1);
      run(lo, hi, n, sp);
    end

    wait_idle();
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
